// File: rtl/priority_code_pkg.sv
// Shared definitions for the priority select-code receiver: link code points,
// receiver FSM states and the code-to-pair decode helper.
package priority_code_pkg;

  localparam logic [3:0] CODE_SYNC = 4'hE;
  localparam logic [3:0] CODE_SEL2 = 4'h2;
  localparam logic [3:0] CODE_SEL1 = 4'h3;
  localparam logic [3:0] CODE_NONE = 4'h1;

  typedef enum logic [1:0] {HUNT, RUN, ERR} state_e;

  // isData marks the three codes that carry a pair; SYNC is legal but carries none.
  typedef struct packed {
    logic sel1;
    logic sel2;
    logic isData;
  } decode_t;

  function automatic decode_t decode_code(input logic [3:0] code);
    decode_t d;
    d = '0;
    case (code)
      CODE_SEL2: d = '{sel1: 1'b0, sel2: 1'b1, isData: 1'b1};
      CODE_SEL1: d = '{sel1: 1'b1, sel2: 1'b0, isData: 1'b1};
      CODE_NONE: d = '{sel1: 1'b0, sel2: 1'b0, isData: 1'b1};
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/priority_code_decoder_fifo.sv
// Small synchronous FIFO holding decoded pairs; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign rdata_o = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (doPush) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (doPop) rptr_q <= rptr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/priority_code_decoder.sv
// Receiver for the sel2-over-sel1 priority code link: locks on SYNC, decodes
// codes to (sel1, sel2) pairs, buffers them, and counts illegal codes.
module priority_code_decoder
  import priority_code_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       code,
  input  logic             code_vld,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_sel1,
  output logic             out_sel2,
  output logic             locked,
  output logic             overflow,
  output logic [ERR_W-1:0] err_cnt
);

  state_e           state_q, state_d;
  decode_t          dec;
  logic             pushPair, countErr, popPair;
  logic             fifoFull, fifoEmpty;
  logic [1:0]       headPair;
  logic             overflow_q, overflow_d;
  logic [ERR_W-1:0] errCnt_q, errCnt_d;

  assign dec = decode_code(code);

  // HUNT and ERR both wait for SYNC; only RUN decodes and counts errors.
  always_comb begin
    state_d  = state_q;
    pushPair = 1'b0;
    countErr = 1'b0;
    if (code_vld) begin
      case (state_q)
        RUN: begin
          if (dec.isData) begin
            pushPair = 1'b1;
          end else if (code != CODE_SYNC) begin
            countErr = 1'b1;
            state_d  = ERR;
          end
        end
        default: if (code == CODE_SYNC) state_d = RUN;
      endcase
    end
  end

  assign popPair    = out_vld && out_rdy;
  assign overflow_d = overflow_q || (pushPair && fifoFull && !popPair);
  assign errCnt_d   = (countErr && (errCnt_q != '1)) ? errCnt_q + 1'b1 : errCnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HUNT;
      overflow_q <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      errCnt_q   <= errCnt_d;
    end
  end

  sync_fifo #(
    .WIDTH(2),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (pushPair),
    .pop_i  (popPair),
    .wdata_i({dec.sel1, dec.sel2}),
    .rdata_o(headPair),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

  assign out_vld  = !fifoEmpty;
  assign out_sel1 = out_vld && headPair[1];
  assign out_sel2 = out_vld && headPair[0];
  assign locked   = (state_q == RUN);
  assign overflow = overflow_q;
  assign err_cnt  = errCnt_q;

endmodule

// File: tb/tb_priority_code_decoder.sv
// Bench for priority_code_decoder: directed scenarios then random traffic,
// checked against a queue-based model; a second instance uses a 2-bit error counter.
module tb_priority_code_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code;
  logic       code_vld;
  logic       out_rdy;

  logic       vldA, sel1A, sel2A, lockedA, overflowA;
  logic [7:0] errA;
  logic       vldB, sel1B, sel2B, lockedB, overflowB;
  logic [1:0] errB;

  int testCount = 0;
  int failCount = 0;

  // Reference model: pair queue, lock flag, sticky overflow, two error counters.
  logic [1:0] mQueue[$];
  bit         mLocked;
  bit         mOverflow;
  int         mErr8;
  int         mErr2;

  always #5 clk = ~clk;

  priority_code_decoder #(.DEPTH(DEPTH), .ERR_W(8)) dutA (
    .clk(clk), .rst(rst), .code(code), .code_vld(code_vld),
    .out_vld(vldA), .out_rdy(out_rdy), .out_sel1(sel1A), .out_sel2(sel2A),
    .locked(lockedA), .overflow(overflowA), .err_cnt(errA)
  );

  priority_code_decoder #(.DEPTH(DEPTH), .ERR_W(2)) dutB (
    .clk(clk), .rst(rst), .code(code), .code_vld(code_vld),
    .out_vld(vldB), .out_rdy(out_rdy), .out_sel1(sel1B), .out_sel2(sel2B),
    .locked(lockedB), .overflow(overflowB), .err_cnt(errB)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mQueue.delete();
    mLocked   = 1'b0;
    mOverflow = 1'b0;
    mErr8     = 0;
    mErr2     = 0;
  endtask

  task automatic modelStep(input logic [3:0] c, input logic v, input logic r);
    bit         popNow;
    bit         pushNow;
    logic [1:0] pair;
    popNow  = r && (mQueue.size() > 0);
    pushNow = 1'b0;
    pair    = 2'b00;
    if (v) begin
      if (!mLocked) begin
        if (c == 4'hE) mLocked = 1'b1;
      end else if (c == 4'h2) begin
        pushNow = 1'b1; pair = 2'b01;
      end else if (c == 4'h3) begin
        pushNow = 1'b1; pair = 2'b10;
      end else if (c == 4'h1) begin
        pushNow = 1'b1; pair = 2'b00;
      end else if (c != 4'hE) begin
        mLocked = 1'b0;
        if (mErr8 < 255) mErr8++;
        if (mErr2 < 3) mErr2++;
      end
    end
    if (popNow) void'(mQueue.pop_front());
    if (pushNow) begin
      if (mQueue.size() < DEPTH) mQueue.push_back(pair);
      else mOverflow = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic v, input logic r);
    @(negedge clk);
    code     = c;
    code_vld = v;
    out_rdy  = r;
    @(posedge clk);
    modelStep(c, v, r);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    bit         expVld;
    logic [1:0] head;
    expVld = (mQueue.size() != 0);
    head   = expVld ? mQueue[0] : 2'b00;
    checkValue({tag, ".out_vld"}, 32'(vldA), 32'(expVld));
    checkValue({tag, ".locked"}, 32'(lockedA), 32'(mLocked));
    checkValue({tag, ".overflow"}, 32'(overflowA), 32'(mOverflow));
    checkValue({tag, ".err_cnt"}, 32'(errA), 32'(mErr8));
    checkValue({tag, ".err_cnt_w2"}, 32'(errB), 32'(mErr2));
    checkValue({tag, ".out_vld_w2"}, 32'(vldB), 32'(expVld));
    checkValue({tag, ".locked_w2"}, 32'(lockedB), 32'(mLocked));
    if (expVld) begin
      checkValue({tag, ".out_sel1"}, 32'(sel1A), 32'(head[1]));
      checkValue({tag, ".out_sel2"}, 32'(sel2A), 32'(head[0]));
      checkValue({tag, ".out_sel1_w2"}, 32'(sel1B), 32'(head[1]));
      checkValue({tag, ".out_sel2_w2"}, 32'(sel2B), 32'(head[0]));
    end
  endtask

  task automatic checkReset(input string tag);
    checkValue({tag, ".out_vld"}, 32'(vldA), 32'd0);
    checkValue({tag, ".out_sel1"}, 32'(sel1A), 32'd0);
    checkValue({tag, ".out_sel2"}, 32'(sel2A), 32'd0);
    checkValue({tag, ".locked"}, 32'(lockedA), 32'd0);
    checkValue({tag, ".overflow"}, 32'(overflowA), 32'd0);
    checkValue({tag, ".err_cnt"}, 32'(errA), 32'd0);
    checkValue({tag, ".err_cnt_w2"}, 32'(errB), 32'd0);
    checkValue({tag, ".overflow_w2"}, 32'(overflowB), 32'd0);
  endtask

  initial begin
    logic [3:0] fillCodes[5];
    logic [3:0] rc;
    int         pick;
    fillCodes = '{4'h2, 4'h3, 4'h1, 4'h3, 4'h2};

    rst = 1'b0; code = 4'h0; code_vld = 1'b0; out_rdy = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkReset("reset");
    @(negedge clk) rst = 1'b1;

    // Data codes before SYNC are ignored.
    applyStimulus(4'h3, 1'b1, 1'b0); checkOutput("preSync3");
    applyStimulus(4'h2, 1'b1, 1'b0); checkOutput("preSync2");

    // In-order decode with consumer always ready.
    applyStimulus(4'hE, 1'b1, 1'b1); checkOutput("sync1");
    applyStimulus(4'h2, 1'b1, 1'b1); checkOutput("dec2");
    applyStimulus(4'h3, 1'b1, 1'b1); checkOutput("dec3");
    applyStimulus(4'h1, 1'b1, 1'b1); checkOutput("dec1");
    applyStimulus(4'h0, 1'b0, 1'b1); checkOutput("decDrain");

    // DEPTH+1 pushes without consumer: last one dropped, then drain.
    applyStimulus(4'hE, 1'b1, 1'b0); checkOutput("sync2");
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(fillCodes[i], 1'b1, 1'b0); checkOutput("fill");
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(4'h0, 1'b0, 1'b1); checkOutput("drain");
    end

    // Simultaneous push and pop on a full FIFO.
    modelReset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    applyStimulus(4'hE, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(fillCodes[i], 1'b1, 1'b0); checkOutput("fullFill");
    end
    applyStimulus(4'h2, 1'b1, 1'b1); checkOutput("fullPushPop");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(4'h0, 1'b0, 1'b1); checkOutput("fullDrain");
    end

    // Illegal code drops lock until next SYNC.
    applyStimulus(4'h7, 1'b1, 1'b1); checkOutput("illegal7");
    applyStimulus(4'h2, 1'b1, 1'b1); checkOutput("errIgnore2");
    applyStimulus(4'h3, 1'b1, 1'b1); checkOutput("errIgnore3");
    applyStimulus(4'hE, 1'b1, 1'b1); checkOutput("resync");
    applyStimulus(4'h2, 1'b1, 1'b1); checkOutput("afterResync");

    // Saturate the narrow counter, then reset mid-drain.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h9, 1'b1, 1'b1); checkOutput("satIllegal");
      applyStimulus(4'hE, 1'b1, 1'b1); checkOutput("satSync");
    end
    applyStimulus(4'h3, 1'b1, 1'b0);
    applyStimulus(4'h2, 1'b1, 1'b0);
    applyStimulus(4'h1, 1'b1, 1'b0); checkOutput("preResetFill");
    applyStimulus(4'h0, 1'b0, 1'b1); checkOutput("preResetDrain");
    #2 rst = 1'b0;
    #1 modelReset();
    checkReset("midReset");
    @(negedge clk) rst = 1'b1;
    applyStimulus(4'h2, 1'b1, 1'b1); checkOutput("postResetNoSync");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1:    rc = 4'hE;
        2, 3:    rc = 4'h2;
        4, 5:    rc = 4'h3;
        6:       rc = 4'h1;
        default: rc = 4'($urandom_range(0, 15));
      endcase
      applyStimulus(rc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
